// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants for the VGA scan controller: the default 640x480@60
// timing (active, front porch, sync, back porch on each axis), the derived
// line/frame totals, the default pixel address width and the sync polarity.
package vga_pkg;

  localparam int DEF_ADDR_WIDTH = 11;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Level driven on oHS/oVS while the sync pulse is asserted.
  localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One scan axis (horizontal or vertical). Counts 0..total-1 while iEn is
// high and decodes the active and sync regions. Count 0 is the first active
// position, followed by front porch, sync and back porch.
//
// Ports
//   iClk    : clock, rising edge
//   iRst    : asynchronous active-high reset, clears the count
//   iEn     : advance the count on this edge
//   oCnt    : current position on the axis
//   oWrap   : high while oCnt is the last position (next advance wraps to 0)
//   oActive : oCnt lies in the active region
//   oSync   : oCnt lies in the sync region (raw, active-high)
module vga_axis_counter #(
  parameter int active = 640,
  parameter int fp     = 16,
  parameter int sync   = 96,
  parameter int bp     = 48,
  localparam int total    = active + fp + sync + bp,
  localparam int cntWidth = $clog2(total)
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  output logic [cntWidth-1:0] oCnt,
  output logic                oWrap,
  output logic                oActive,
  output logic                oSync
);

  assign oWrap   = (oCnt == cntWidth'(total - 1));
  assign oActive = (oCnt < cntWidth'(active));
  assign oSync   = (oCnt >= cntWidth'(active + fp)) &&
                   (oCnt <  cntWidth'(active + fp + sync));

  // Position counter; holds whenever the axis is not enabled.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oCnt <= '0;
    end else if (iEn) begin
      oCnt <= oWrap ? '0 : oCnt + cntWidth'(1);
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl
// VGA raster scan controller. Walks the frame one pixel per enabled cycle,
// presents the pixel address to an external combinational pixel source and
// registers the returned colour together with sync, blank and frame-start
// flags so that every output refers to the same pixel, one enabled cycle
// after the counters pointed at it.
//
// Ports
//   iClk, iRst             : pixel clock / asynchronous active-high reset
//   iPixEn                 : pixel enable; nothing advances while low
//   oHAddr, oVAddr         : pixel address to the source (0 outside active)
//   iRed, iGreen, iBlue    : colour returned by the source for that address
//   oVGA_R, oVGA_G, oVGA_B : registered colour to the DAC (0 in blanking)
//   oHS, oVS               : active-low sync pulses
//   oBlank_n               : high while the output pixel is active
//   oFrameStart            : high for the output pixel (0,0)
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int addrWidth = DEF_ADDR_WIDTH,
  parameter int H_ACT     = DEF_H_ACT,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iPixEn,
  output logic [addrWidth-1:0] oHAddr,
  output logic [addrWidth-1:0] oVAddr,
  input  logic [7:0]           iRed,
  input  logic [7:0]           iGreen,
  input  logic [7:0]           iBlue,
  output logic [7:0]           oVGA_R,
  output logic [7:0]           oVGA_G,
  output logic [7:0]           oVGA_B,
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oBlank_n,
  output logic                 oFrameStart
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  logic [H_W-1:0] hCnt;
  logic [V_W-1:0] vCnt;
  logic hWrap, hActive, hSyncRaw;
  logic vWrap, vActive, vSyncRaw;
  logic vEn;
  logic active;
  logic atOrigin;

  // The vertical axis steps once per line, on the edge where the
  // horizontal axis wraps.
  assign vEn = iPixEn & hWrap;

  vga_axis_counter #(
    .active(H_ACT), .fp(H_FP), .sync(H_SYNC), .bp(H_BP)
  ) hAxis (
    .iClk(iClk), .iRst(iRst), .iEn(iPixEn),
    .oCnt(hCnt), .oWrap(hWrap), .oActive(hActive), .oSync(hSyncRaw)
  );

  vga_axis_counter #(
    .active(V_ACT), .fp(V_FP), .sync(V_SYNC), .bp(V_BP)
  ) vAxis (
    .iClk(iClk), .iRst(iRst), .iEn(vEn),
    .oCnt(vCnt), .oWrap(vWrap), .oActive(vActive), .oSync(vSyncRaw)
  );

  assign active = hActive & vActive;

  // Addresses follow the counters directly so the source has a full cycle
  // to return the colour; outside the active area they are parked at 0.
  assign oHAddr = active ? addrWidth'(hCnt) : '0;
  assign oVAddr = active ? addrWidth'(vCnt) : '0;

  // Output stage. atOrigin tracks "counters are at (0,0)": it is set by
  // reset and re-armed on the enabled edge where both axes wrap together,
  // which is exactly when the counters return to the origin.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oVGA_R      <= 8'h00;
      oVGA_G      <= 8'h00;
      oVGA_B      <= 8'h00;
      oHS         <= ~SYNC_ACTIVE;
      oVS         <= ~SYNC_ACTIVE;
      oBlank_n    <= 1'b0;
      oFrameStart <= 1'b0;
      atOrigin    <= 1'b1;
    end else if (iPixEn) begin
      oVGA_R      <= active ? iRed   : 8'h00;
      oVGA_G      <= active ? iGreen : 8'h00;
      oVGA_B      <= active ? iBlue  : 8'h00;
      oHS         <= hSyncRaw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      oVS         <= vSyncRaw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      oBlank_n    <= active;
      oFrameStart <= atOrigin;
      atOrigin    <= hWrap & vWrap;
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameter addrWidth, default 11, pixel address width for hAddr/vAddr.
REQ-002 SHALL have parameters H_ACT/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACT/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 Port iClk  input  1  pixel-domain clock, rising edge.
REQ-005 Port iRst  input  1  reset; the block has one clock, and reset is asynchronous and active-high.
REQ-006 Port iPixEn  input  1  pixel-clock enable; all state advances only on cycles where iPixEn=1.
REQ-007 Port oHAddr  output  addrWidth  horizontal pixel address sent to the pixel source.
REQ-008 Port oVAddr  output  addrWidth  vertical pixel address sent to the pixel source.
REQ-009 Port iRed/iGreen/iBlue  input  8 each  pixel colour returned combinationally by the pixel source for the current oHAddr/oVAddr.
REQ-010 Port oVGA_R/oVGA_G/oVGA_B  output  8 each  registered colour to the DAC.
REQ-011 Port oHS, oVS  output  1 each  sync pulses, active-low.
REQ-012 Port oBlank_n  output  1  high when the output pixel is in the active area.
REQ-013 Port oFrameStart  output  1  one-enabled-cycle pulse coincident with output pixel (0,0).

Function
REQ-014 The horizontal counter hCnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACT+H_FP+H_SYNC+H_BP=800), incrementing on each iPixEn, and SHALL wrap to 0.
REQ-015 The vertical counter vCnt SHALL increment only when hCnt wraps, SHALL count 0..V_TOTAL-1 (525), and SHALL wrap to 0 when both counters wrap together.
REQ-016 Count 0 on each axis SHALL be the first active pixel/line, followed by the front porch, sync and back porch regions.
REQ-017 Active SHALL be (hCnt<H_ACT)&&(vCnt<V_ACT).
REQ-018 When active, oHAddr=hCnt and oVAddr=vCnt; otherwise both SHALL be 0; both outputs are combinational from the counters.
REQ-019 hSyncRaw SHALL be asserted for H_ACT+H_FP <= hCnt < H_ACT+H_FP+H_SYNC (656..751).
REQ-020 vSyncRaw SHALL be asserted for V_ACT+V_FP <= vCnt < V_ACT+V_FP+V_SYNC (490..491).
REQ-021 Output stage: on each iPixEn, the block SHALL register iRed/iGreen/iBlue when active, and 0 otherwise.
REQ-022 On the same edge, the block SHALL register oHS=~hSyncRaw, oVS=~vSyncRaw, oBlank_n=active, and oFrameStart=(hCnt==0&&vCnt==0).
REQ-023 Latency from counter state to the outputs SHALL be exactly 1 enabled cycle, with all outputs mutually aligned.
REQ-024 When iPixEn=0, counters and all registered outputs SHALL hold their values.
REQ-025 Counter widths SHALL be $clog2 of the totals; addresses SHALL be zero-extended/truncated to addrWidth without wrap artefacts for the default parameters.

Reset
REQ-026 While iRst=1, hCnt=0 and vCnt=0 SHALL hold; registered outputs SHALL be RGB=0, oHS=1, oVS=1, oBlank_n=0, oFrameStart=0.
REQ-027 Reset mid-frame SHALL abort immediately (asynchronous).
REQ-028 On the first enabled cycle after deassertion, the outputs SHALL show pixel (0,0) with oFrameStart=1.

Structure
REQ-029 Package vga_pkg SHALL hold the default timing constants, the H_TOTAL/V_TOTAL derivations and the sync polarity constant.
REQ-030 One sub-module, vga_axis_counter, SHALL be used (parameters: active/fp/sync/bp; ports: iClk, iRst, iEn, oCnt, oWrap, oActive, oSync), instantiated for H and V.
REQ-031 The V instance's iEn SHALL be driven by iPixEn & H oWrap.

Verification
REQ-032 Reset release, iPixEn=1 -> the first output cycle has oFrameStart=1, oBlank_n=1, and RGB equal to source(0,0).
REQ-033 Run one line -> oBlank_n is high for 640 cycles; oHS is low for exactly 96 cycles starting 656 cycles after line start; the period is 800.
REQ-034 Run a full frame with the cube source -> pixel (300,350) is output as DA/D7/C0, (0,0) as A3/B1/8A, and oVS is low for 2 lines at lines 490-491; the frame is 420000 enabled cycles.
REQ-035 iPixEn toggling 1/0 -> line length is 1600 clocks and outputs hold on disabled cycles.
REQ-036 iRst asserted at hCnt=700,vCnt=300 -> outputs go to their reset values without waiting for a clock, and the next frame restarts at (0,0).
REQ-037 Constant source RGB=FF/FF/FF -> output RGB is 0 in every blanking cycle.
